tensor_write_sequencer: RTL and testbench
=========================================

Name: tensor_write_sequencer

Overview:
Upstream feeder for the 8x8x3 tensor register array (WIDTH-bit signed elements).
- Accepts a valid/ready stream of unsigned pixel samples in raster order, channel fastest, then column, then row.
- Converts each sample to signed fixed point and drives the array's row/col/channel write address and data.
- Signals tile completion and holds off input until the consumer acknowledges the tile.

Parameters:
WIDTH, 17, output element width (signed two's complement)
PIX_W, 8, input pixel width (unsigned)
SHIFT, 8, left shift applied after re-centring
ROWS, 8, tensor rows
COLS, 8, tensor columns
CHANS, 3, channels per pixel

Ports:
clk  in  1  clock
rst  in  1  reset: synchronous, active-high
s_valid  in  1  input sample valid
s_ready  out  1  block accepts a sample this cycle
s_data  in  PIX_W  unsigned pixel sample
s_last  in  1  final-beat marker; used only with TILE_LAST_CHECK_EN
row_addr  out  $clog2(ROWS)  tensor row write address
col_addr  out  $clog2(COLS)  tensor column write address
cha_addr  out  $clog2(CHANS)  tensor channel write address
data_out  out  WIDTH  converted element
wr_en  out  1  a new element is presented this cycle
tile_done  out  1  level; the tensor holds a complete tile
tile_ack  in  1  consumer has taken the tile; starts the next fill
error  out  1  sticky framing error

Behaviour:
Reset:
- State FILL; counters 0; row/col/cha_addr=0; data_out=0; wr_en=0; tile_done=0; error=0.
- s_ready=1 from the first cycle after reset.
- Reset mid-tile discards the partial tile.

Accept rule:
- A beat is accepted when s_valid && s_ready at a rising edge.

Latency:
- Accept at edge N loads the addresses (current counters), data_out and wr_en=1 at edge N.
- The tensor captures the element at edge N+1.
- Without an accept, wr_en=0 and addr/data_out hold their last values. An unconditional downstream rewrite is therefore idempotent.

Conversion:
- v = (s_data - 2^(PIX_W-1)) << SHIFT, computed at full precision.
- Saturate v to the signed WIDTH range.
- With defaults: 0 -> -32768 (17'h18000), 128 -> 0, 255 -> 32512 (17'h07F00); saturation never triggers.

Counters:
- cha increments 0..CHANS-1 and wraps to 0, carrying into col.
- col 0..COLS-1 wraps and carries into row.
- row 0..ROWS-1.

FSM:
- FILL: s_ready=1. Accepting the beat at (ROWS-1, COLS-1, CHANS-1) moves to DRAIN; counters clear to 0.
- DRAIN (1 cycle): s_ready=0, so the final write lands in the tensor. Then moves to DONE.
- DONE: s_ready=0, tile_done=1. tile_ack=1 moves to FILL; tile_done=0 and s_ready=1 in the next cycle.
- tile_ack in FILL or DRAIN is ignored; it is not remembered.
- s_valid asserted in DRAIN or DONE: beat not accepted; upstream holds s_data.

Throughput:
- One element per cycle in FILL.
- Tile period is ROWS*COLS*CHANS + 2 cycles, plus the ack wait.

Simultaneous events:
- rst overrides everything, including an accept or tile_ack in the same cycle.

Optional Feature:
TILE_LAST_CHECK_EN
- Defined: on each accepted beat, error is set if s_last=1 on a non-final beat or s_last=0 on the final beat.
  - The beat is still written and the counters advance normally; no resynchronisation.
  - error is sticky and cleared only by rst.
- Undefined: s_last is ignored and error is tied to 0.

Test Plan:
1. Assert rst for 3 cycles mid-stream -> all outputs 0 next cycle; s_ready=1 the cycle after rst drops.
2. Stream 192 continuous beats with s_data = index mod 256:
   - beat 0 -> (0,0,0), data_out=17'h18000;
   - beat 3 -> (0,1,0);
   - beat 24 -> (1,0,0);
   - beat 191 -> (7,7,2);
   - s_ready=0 the cycle after beat 191; tile_done=1 two cycles after the final accept.
3. Apply s_valid with a 1-on/2-off pattern over 10 beats -> wr_en pulses exactly 10 times; addr/data_out unchanged in non-accept cycles; addresses step 0..9 in channel-fastest order.
4. In DONE, hold s_valid=1 for 5 cycles, then pulse tile_ack -> no accepts before the ack; the first post-ack beat writes (0,0,0). A tile_ack pulse during FILL has no effect.
5. Assert rst after 50 accepted beats -> the next accepted beat writes (0,0,0); tile_done appears only after 192 further beats.
6. Build with TILE_LAST_CHECK_EN:
   - s_last=1 on beat 100 -> error=1 from the next cycle, staying high through the tile; the tile still completes.
   - A fresh run with s_last only on beat 191 -> error stays 0.

Source files
------------

// File: rtl/tensor_write_sequencer.sv
// Feeds the ROWSxCOLSxCHANS tensor register array from a raster-order pixel stream.
// Optional framing check on s_last is built when TILE_LAST_CHECK_EN is defined.
module tensor_write_sequencer #(
    parameter int WIDTH = 17,
    parameter int PIX_W = 8,
    parameter int SHIFT = 8,
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CHANS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [PIX_W-1:0]         s_data,
    input  logic                     s_last,
    output logic [$clog2(ROWS)-1:0]  row_addr,
    output logic [$clog2(COLS)-1:0]  col_addr,
    output logic [$clog2(CHANS)-1:0] cha_addr,
    output logic [WIDTH-1:0]         data_out,
    output logic                     wr_en,
    output logic                     tile_done,
    input  logic                     tile_ack,
    output logic                     error
);

    localparam int RW     = $clog2(ROWS);
    localparam int CW     = $clog2(COLS);
    localparam int HW     = $clog2(CHANS);
    localparam int FULL_W = PIX_W + 1 + SHIFT;
    localparam int EXT_W  = ((FULL_W > WIDTH) ? FULL_W : WIDTH) + 1;

    localparam logic signed [EXT_W-1:0] HALF    = EXT_W'(1) << (PIX_W - 1);
    localparam logic signed [EXT_W-1:0] SAT_MAX = (EXT_W'(1) << (WIDTH - 1)) - EXT_W'(1);
    localparam logic signed [EXT_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {FILL, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [RW-1:0]    row_q, row_d;
    logic [CW-1:0]    col_q, col_d;
    logic [HW-1:0]    cha_q, cha_d;
    logic [RW-1:0]    row_addr_q, row_addr_d;
    logic [CW-1:0]    col_addr_q, col_addr_d;
    logic [HW-1:0]    cha_addr_q, cha_addr_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             wr_en_q, wr_en_d;

    logic                    accept;
    logic                    last_beat;
    logic signed [EXT_W-1:0] centred;
    logic signed [EXT_W-1:0] shifted;
    logic [WIDTH-1:0]        conv;

    assign s_ready   = (state_q == FILL);
    assign tile_done = (state_q == DONE);
    assign accept    = s_valid && s_ready;
    assign last_beat = (row_q == RW'(ROWS - 1)) && (col_q == CW'(COLS - 1)) && (cha_q == HW'(CHANS - 1));

    // Re-centre the unsigned sample, scale it, then clamp into the signed output range.
    always_comb begin
        centred = EXT_W'($signed({1'b0, s_data})) - HALF;
        shifted = centred <<< SHIFT;
        if (shifted > SAT_MAX) begin
            conv = SAT_MAX[WIDTH-1:0];
        end else if (shifted < SAT_MIN) begin
            conv = SAT_MIN[WIDTH-1:0];
        end else begin
            conv = shifted[WIDTH-1:0];
        end
    end

    always_comb begin
        // NOTE: every next-state value gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        row_d      = row_q;
        col_d      = col_q;
        cha_d      = cha_q;
        row_addr_d = row_addr_q;
        col_addr_d = col_addr_q;
        cha_addr_d = cha_addr_q;
        data_d     = data_q;
        wr_en_d    = 1'b0;
        unique case (state_q)
            FILL: begin
                if (accept) begin
                    row_addr_d = row_q;
                    col_addr_d = col_q;
                    cha_addr_d = cha_q;
                    data_d     = conv;
                    wr_en_d    = 1'b1;
                    if (last_beat) begin
                        row_d   = '0;
                        col_d   = '0;
                        cha_d   = '0;
                        state_d = DRAIN;
                    end else if (cha_q != HW'(CHANS - 1)) begin
                        cha_d = cha_q + HW'(1);
                    end else begin
                        cha_d = '0;
                        if (col_q != CW'(COLS - 1)) begin
                            col_d = col_q + CW'(1);
                        end else begin
                            col_d = '0;
                            row_d = row_q + RW'(1);
                        end
                    end
                end
            end
            // One idle cycle lets the tensor capture the final element before tile_done rises.
            DRAIN:   state_d = DONE;
            DONE:    if (tile_ack) state_d = FILL;
            default: state_d = FILL;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            row_q      <= '0;
            col_q      <= '0;
            cha_q      <= '0;
            row_addr_q <= '0;
            col_addr_q <= '0;
            cha_addr_q <= '0;
            data_q     <= '0;
            wr_en_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            col_q      <= col_d;
            cha_q      <= cha_d;
            row_addr_q <= row_addr_d;
            col_addr_q <= col_addr_d;
            cha_addr_q <= cha_addr_d;
            data_q     <= data_d;
            wr_en_q    <= wr_en_d;
        end
    end

    assign row_addr = row_addr_q;
    assign col_addr = col_addr_q;
    assign cha_addr = cha_addr_q;
    assign data_out = data_q;
    assign wr_en    = wr_en_q;

`ifdef TILE_LAST_CHECK_EN
    logic error_q, error_d;

    // Framing violations are only recorded; the beat is still written and counting continues.
    assign error_d = error_q | (accept && (s_last != last_beat));

    always_ff @(posedge clk) begin
        if (rst) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error = error_q;
`else
    logic unused_s_last;
    assign unused_s_last = s_last;
    assign error         = 1'b0;
`endif

endmodule

// File: tb/tb_tensor_write_sequencer.sv
// Self-checking bench for tensor_write_sequencer: conversion table, scoreboard of writes, FSM corner sequences.
module tb_tensor_write_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data = '0;
    logic        s_last = 1'b0;
    logic [2:0]  row_addr;
    logic [2:0]  col_addr;
    logic [1:0]  cha_addr;
    logic [16:0] data_out;
    logic        wr_en;
    logic        tile_done;
    logic        tile_ack = 1'b0;
    logic        error;

    always #5 clk = ~clk;

    tensor_write_sequencer dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .s_last   (s_last),
        .row_addr (row_addr),
        .col_addr (col_addr),
        .cha_addr (cha_addr),
        .data_out (data_out),
        .wr_en    (wr_en),
        .tile_done(tile_done),
        .tile_ack (tile_ack),
        .error    (error)
    );

    typedef struct {
        logic [7:0]  din;
        logic [16:0] dout;
    } conv_vec_t;

    typedef struct {
        logic [2:0]  r;
        logic [2:0]  c;
        logic [1:0]  ch;
        logic [16:0] d;
    } exp_t;

    conv_vec_t vecs[6];
    exp_t      sb[$];
    exp_t      last_w;

    int n_checks = 0;
    int n_fail   = 0;
    int m_idx    = 0;
    bit m_drain  = 0;
    bit m_done   = 0;
    bit m_err    = 0;
    int wr_count = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] ref_conv(input int d);
        int v;
        v = (d - 128) * 256;
        if (v > 65535)  v = 65535;
        if (v < -65536) v = -65536;
        return v[16:0];
    endfunction

    // One clock of stimulus; the model predicts acceptance and the scoreboard checks the write.
    task automatic step(input bit v, input logic [7:0] d, input bit l, input bit a);
        bit   exp_rdy;
        bit   acc;
        exp_t e;
        s_valid  = v;
        s_data   = d;
        s_last   = l;
        tile_ack = a;
        exp_rdy  = !m_drain && !m_done;
        check("s_ready", s_ready, exp_rdy);
        acc = v && exp_rdy;
        if (acc) begin
            e.r  = 3'(m_idx / 24);
            e.c  = 3'((m_idx / 3) % 8);
            e.ch = 2'(m_idx % 3);
            e.d  = ref_conv(int'(d));
            sb.push_back(e);
`ifdef TILE_LAST_CHECK_EN
            if (l != (m_idx == 191)) m_err = 1'b1;
`endif
        end
        @(posedge clk);
        #1;
        if (acc) begin
            m_idx++;
            if (m_idx == 192) begin
                m_idx   = 0;
                m_drain = 1'b1;
            end
        end else if (m_drain) begin
            m_drain = 1'b0;
            m_done  = 1'b1;
        end else if (m_done && a) begin
            m_done = 1'b0;
        end
        check("wr_en", wr_en, acc);
        if (acc) begin
            e = sb.pop_front();
            check("wr_addr", {row_addr, col_addr, cha_addr}, {e.r, e.c, e.ch});
            check("wr_data", data_out, e.d);
            last_w = e;
        end else begin
            check("hold_addr", {row_addr, col_addr, cha_addr}, {last_w.r, last_w.c, last_w.ch});
            check("hold_data", data_out, last_w.d);
        end
        check("tile_done", tile_done, m_done);
        check("error", error, m_err);
        if (wr_en) wr_count++;
    endtask

    // Reset with an accept and an ack pending, to show reset takes priority.
    task automatic do_reset(input int n);
        rst      = 1'b1;
        s_valid  = 1'b1;
        s_data   = 8'h55;
        tile_ack = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
            check("rst_wr_en", wr_en, 1'b0);
            check("rst_addr", {row_addr, col_addr, cha_addr}, 8'h00);
            check("rst_data", data_out, 17'h0);
            check("rst_tile_done", tile_done, 1'b0);
            check("rst_error", error, 1'b0);
        end
        rst      = 1'b0;
        s_valid  = 1'b0;
        tile_ack = 1'b0;
        m_idx    = 0;
        m_drain  = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
        last_w   = '{default: '0};
        sb.delete();
        check("ready_after_rst", s_ready, 1'b1);
    endtask

    task automatic run_beats(input int n, input int last_at);
        for (int i = 0; i < n; i++) begin
            step(1'b1, 8'(m_idx), (m_idx == last_at), 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{8'd0,   17'h18000};
        vecs[1] = '{8'd128, 17'h00000};
        vecs[2] = '{8'd255, 17'h07F00};
        vecs[3] = '{8'd1,   17'h18100};
        vecs[4] = '{8'd127, 17'h1FF00};
        vecs[5] = '{8'd129, 17'h00100};
        last_w  = '{default: '0};

        do_reset(3);

        for (int i = 0; i < 6; i++) begin
            step(1'b1, vecs[i].din, 1'b0, 1'b0);
            check("conv_table", data_out, vecs[i].dout);
        end

        // Mid-stream reset discards the partial tile.
        do_reset(3);

        // Full tile, continuous stream.
        for (int i = 0; i < 192; i++) begin
            step(1'b1, 8'(i % 256), (i == 191), 1'b0);
            if (i == 0) begin
                check("beat0_addr", {row_addr, col_addr, cha_addr}, {3'd0, 3'd0, 2'd0});
                check("beat0_data", data_out, 17'h18000);
            end
            if (i == 3)   check("beat3_addr", {row_addr, col_addr, cha_addr}, {3'd0, 3'd1, 2'd0});
            if (i == 24)  check("beat24_addr", {row_addr, col_addr, cha_addr}, {3'd1, 3'd0, 2'd0});
            if (i == 191) check("beat191_addr", {row_addr, col_addr, cha_addr}, {3'd7, 3'd7, 2'd2});
        end
        check("drain_not_ready", s_ready, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("done_after_drain", tile_done, 1'b1);

        // Upstream keeps asserting valid while DONE; nothing is accepted before the ack.
        wr_count = 0;
        repeat (5) step(1'b1, 8'hAA, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b1);
        check("no_accept_in_done", wr_count, 0);
        step(1'b1, 8'hAA, 1'b0, 1'b0);
        check("post_ack_addr", {row_addr, col_addr, cha_addr}, 8'h00);

        // Sparse valid with a stray ack during FILL.
        do_reset(1);
        wr_count = 0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 8'(37 * i), 1'b0, 1'b0);
            step(1'b0, 8'hFF, 1'b0, (i == 4));
            step(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("sparse_wr_count", wr_count, 10);
        check("sparse_last_addr", {row_addr, col_addr, cha_addr}, {3'd0, 3'd3, 2'd0});

        // Reset after 50 accepted beats; a full fresh tile is then required.
        run_beats(40, 191);
        check("fifty_beats", m_idx, 50);
        do_reset(2);
        step(1'b1, 8'd9, 1'b0, 1'b0);
        check("post_rst_addr", {row_addr, col_addr, cha_addr}, 8'h00);
        run_beats(191, 191);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        check("tile_done_after_192", wr_count, 10 + 40 + 192);

`ifdef TILE_LAST_CHECK_EN
        do_reset(1);
        run_beats(100, 191);
        step(1'b1, 8'd100, 1'b1, 1'b0);
        check("err_after_beat100", error, 1'b1);
        run_beats(91, 191);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("err_tile_done", tile_done, 1'b1);
        check("err_sticky", error, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b1);
        do_reset(1);
        run_beats(192, 191);
        step(1'b0, 8'h00, 1'b0, 1'b0);
        check("clean_tile_err", error, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b1);
`else
        for (int i = 0; i < 30; i++) begin
            step(1'b1, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)), 1'b0);
        end
        check("err_tied_low", error, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
